// File: rtl/fetch_queue.sv
// Instruction fetch producer: one outstanding imem request, predictor-driven next PC,
// and a circular FIFO of fetched entries presented to decode, with mispredict flush.
package fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] out_inst;
        logic        prediction;
    } if_id_stage_reg_t;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_resp,
    input  logic             pred_taken,
    input  logic [31:0]      pred_target,
    input  logic             branch,
    input  logic [31:0]      branch_target,
    input  logic             deq,
    output logic             empty,
    output if_id_stage_reg_t if_id_reg
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_req_addr;
    logic             r_pred_taken_q;
    logic [31:0]      r_pred_target_q;
    if_id_stage_reg_t r_mem [DEPTH];

    logic             w_issue;
    logic             w_enq;
    logic             w_deq;
    if_id_stage_reg_t w_entry;

    // Next state, issue and enqueue decisions; a flush suppresses both.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_enq        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst && !branch && (r_count < CW'(DEPTH))) begin
                    w_issue      = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (branch) begin
                    w_state_next = imem_resp ? IDLE : DISCARD;
                end else if (imem_resp) begin
                    w_enq        = 1'b1;
                    w_state_next = IDLE;
                end
            end
            DISCARD: begin
                if (imem_resp) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_deq = deq && (r_count != '0) && !branch;

    always_comb begin
        w_entry.pc         = r_req_addr;
        w_entry.pc_next    = r_pred_taken_q ? r_pred_target_q : (r_req_addr + 32'd4);
        w_entry.out_inst   = imem_rdata;
        w_entry.prediction = r_pred_taken_q;
    end

    // Address is held from issue until the response, even across a flush.
    assign imem_addr  = (r_state == IDLE) ? r_fetch_pc : r_req_addr;
    assign imem_rmask = (w_issue || (r_state != IDLE)) ? 4'hF : 4'h0;
    assign empty      = (r_count == '0);
    assign if_id_reg  = empty ? '0 : r_mem[r_head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_count         <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_fetch_pc      <= RESET_PC;
            r_req_addr      <= RESET_PC;
            r_pred_taken_q  <= 1'b0;
            r_pred_target_q <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_req_addr      <= r_fetch_pc;
                r_pred_taken_q  <= pred_taken;
                r_pred_target_q <= {pred_target[31:2], 2'b00};
            end
            if (branch) begin
                r_count    <= '0;
                r_head     <= r_tail;
                r_fetch_pc <= {branch_target[31:2], 2'b00};
            end else begin
                if (w_enq) begin
                    r_tail     <= r_tail + PW'(1);
                    r_fetch_pc <= w_entry.pc_next;
                end
                if (w_deq) r_head <= r_head + PW'(1);
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only read while count covers them.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= w_entry;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: acts as instruction memory and predictor, and
// checks every cycle against a queue-based model of the fetch/flush rules.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic             clk;
    logic             rst;
    logic [31:0]      imem_addr;
    logic [3:0]       imem_rmask;
    logic [31:0]      imem_rdata;
    logic             imem_resp;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             branch;
    logic [31:0]      branch_target;
    logic             deq;
    logic             empty;
    if_id_stage_reg_t if_id_reg;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .pred_taken(pred_taken),
        .pred_target(pred_target), .branch(branch), .branch_target(branch_target),
        .deq(deq), .empty(empty), .if_id_reg(if_id_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents, next fetch PC, and the outstanding request.
    if_id_stage_reg_t q[$];
    logic [31:0]      m_fetch_pc;
    logic             m_pending;
    logic             m_drop;
    logic [31:0]      m_req_addr;
    logic             m_pt;
    logic [31:0]      m_ptg;
    int               lat;
    int               force_lat  = -1;
    logic [31:0]      fix_rdata  = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic stray);
        rst        = 1'b1;
        deq        = 1'b0;
        branch     = 1'b0;
        imem_resp  = stray;
        imem_rdata = 32'hdeadbeef;
        #1;
        check("rst_empty", 128'(empty), 128'(1'b1));
        check("rst_rmask", 128'(imem_rmask), 128'(4'h0));
        check("rst_addr", 128'(imem_addr), 128'(RESET_PC));
        check("rst_head", 128'(if_id_reg), 128'(0));
        @(posedge clk);
        @(negedge clk);
        imem_resp  = 1'b0;
        rst        = 1'b0;
        q.delete();
        m_pending  = 1'b0;
        m_drop     = 1'b0;
        m_fetch_pc = RESET_PC;
    endtask

    task automatic cycle(input logic d, input logic b, input logic [31:0] bt,
                         input logic pt, input logic [31:0] ptg);
        logic             resp_now;
        logic             issue;
        logic [31:0]      rd;
        if_id_stage_reg_t e;
        if_id_stage_reg_t exp_head;
        resp_now      = m_pending && (lat == 0);
        rd            = (fix_rdata != 0) ? fix_rdata : ($urandom | 32'h1);
        deq           = d;
        branch        = b;
        branch_target = bt;
        pred_taken    = pt;
        pred_target   = ptg;
        imem_resp     = resp_now;
        imem_rdata    = rd;
        #1;
        exp_head = (q.size() != 0) ? q[0] : '0;
        issue    = !m_pending && (q.size() < DEPTH) && !b;
        check("empty", 128'(empty), 128'(q.size() == 0));
        check("head", 128'(if_id_reg), 128'(exp_head));
        check("rmask", 128'(imem_rmask), 128'((m_pending || issue) ? 4'hF : 4'h0));
        check("addr", 128'(imem_addr), 128'(m_pending ? m_req_addr : m_fetch_pc));

        if (m_pending && !resp_now) lat--;
        if (b) begin
            q.delete();
            m_fetch_pc = bt & ~32'h3;
            if (m_pending) begin
                if (resp_now) begin
                    m_pending = 1'b0;
                    m_drop    = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            if (d && (q.size() > 0)) void'(q.pop_front());
            if (m_pending && resp_now) begin
                if (!m_drop) begin
                    e.pc         = m_req_addr;
                    e.pc_next    = m_pt ? m_ptg : m_req_addr + 32'd4;
                    e.out_inst   = rd;
                    e.prediction = m_pt;
                    q.push_back(e);
                    m_fetch_pc = e.pc_next;
                end
                m_pending = 1'b0;
                m_drop    = 1'b0;
            end
            if (issue) begin
                m_pending  = 1'b1;
                m_req_addr = m_fetch_pc;
                m_pt       = pt;
                m_ptg      = ptg & ~32'h3;
                lat        = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; deq = 1'b0; branch = 1'b0; branch_target = '0;
        pred_taken = 1'b0; pred_target = '0; imem_resp = 1'b0; imem_rdata = '0;
        m_pending = 1'b0; m_drop = 1'b0; m_fetch_pc = RESET_PC; m_req_addr = RESET_PC;
        m_pt = 1'b0; m_ptg = '0; lat = 0;
        @(negedge clk);

        // First fetch after reset, memory answering one cycle later.
        do_reset(1'b0);
        force_lat = 0;
        fix_rdata = 32'h00000013;
        check("t1_addr", 128'(imem_addr), 128'(32'h1eceb000));
        idle();
        idle();
        check("t1_pc", 128'(if_id_reg.pc), 128'(32'h1eceb000));
        check("t1_pcn", 128'(if_id_reg.pc_next), 128'(32'h1eceb004));
        check("t1_inst", 128'(if_id_reg.out_inst), 128'(32'h00000013));
        check("t1_empty", 128'(empty), 128'(1'b0));
        fix_rdata = '0;

        // Fill without dequeuing; the queue stops at DEPTH and stops fetching.
        force_lat = -1;
        repeat (40) idle();
        check("t2_full_rmask", 128'(imem_rmask), 128'(4'h0));
        check("t2_full_empty", 128'(empty), 128'(1'b0));
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t2_refetch", 128'(imem_rmask), 128'(4'hF));

        // Predicted-taken fetch at 1eceb008.
        do_reset(1'b0);
        force_lat = 0;
        repeat (6) cycle(1'b0, 1'b0, 32'h0,
                         (m_fetch_pc == 32'h1eceb008) && !m_pending, 32'h1eceb100);
        check("t3_addr", 128'(imem_addr), 128'(32'h1eceb100));
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t3_pcn", 128'(if_id_reg.pc_next), 128'(32'h1eceb100));
        check("t3_pred", 128'(if_id_reg.prediction), 128'(1'b1));

        // Flush mid-request; the old response arrives three cycles later.
        do_reset(1'b0);
        force_lat = 3;
        idle();
        cycle(1'b0, 1'b1, 32'h1eceb200, 1'b0, 32'h0);
        check("t4_empty", 128'(empty), 128'(1'b1));
        force_lat = 0;
        repeat (3) idle();
        check("t4_dropped", 128'(empty), 128'(1'b1));
        check("t4_addr", 128'(imem_addr), 128'(32'h1eceb200));

        // Flush in the same cycle as the response.
        idle();
        cycle(1'b0, 1'b1, 32'h1eceb300, 1'b0, 32'h0);
        check("t5_empty", 128'(empty), 128'(1'b1));
        check("t5_addr", 128'(imem_addr), 128'(32'h1eceb300));
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Random traffic: fill-biased first, then balanced, with flushes and resets.
        force_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                cycle((i < 1000) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)),
                      $urandom_range(0, 31) == 0,
                      $urandom,
                      $urandom_range(0, 3) == 0,
                      $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
